// File: rtl/sprint2_rom_loader_if.sv
// ============================================================================
// Module  : sprint2_rom_loader_if
// Purpose : ioctl download stream in, per-region ROM write port out.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface sprint2_rom_loader_if;
    logic        dn_download;
    logic        dn_wr;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic [3:0]  rom_we;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (
        output dn_download,
        output dn_wr,
        output dn_addr,
        output dn_data,
        input  rom_we,
        input  rom_addr,
        input  rom_data
    );

    modport slave (
        input  dn_download,
        input  dn_wr,
        input  dn_addr,
        input  dn_data,
        output rom_we,
        output rom_addr,
        output rom_data
    );
endinterface

`default_nettype wire

// File: rtl/sprint2_rom_loader.sv
// ============================================================================
// Module  : sprint2_rom_loader
// Purpose : Splits the ioctl ROM download into four Sprint 2 ROM regions and
//           owns the core reset (held through download plus a settle delay).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sprint2_rom_loader #(
    parameter logic [15:0] R0_END     = 16'h2000,
    parameter logic [15:0] R1_END     = 16'h2800,
    parameter logic [15:0] R2_END     = 16'h3000,
    parameter logic [15:0] R3_END     = 16'h3800,
    parameter int          SETTLE_CYC = 1024
) (
    input  wire logic               clk_sys,
    input  wire logic               Reset_n,
    sprint2_rom_loader_if.slave     bus,
    input  wire logic               ext_reset,
    output logic                    core_reset_n,
    output logic                    dl_busy,
    output logic                    dl_error,
    output logic [16:0]             byte_count
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] C_CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);

    localparam logic [16:0] C_R0_END = {1'b0, R0_END};
    localparam logic [16:0] C_R1_END = {1'b0, R1_END};
    localparam logic [16:0] C_R2_END = {1'b0, R2_END};
    localparam logic [16:0] C_R3_END = {1'b0, R3_END};
    localparam logic [16:0] C_CNT_MAX = 17'h1FFFF;

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] settle_cnt;

    logic [3:0]  w_sel;
    logic [12:0] w_off;
    logic        w_hit;
    logic [16:0] w_cnt_next;

    // Region decode; the offset is truncated to the 13-bit ROM address bus
    always_comb begin
        w_sel = 4'b0000;
        w_off = 13'd0;
        if (bus.dn_addr < C_R0_END) begin
            w_sel = 4'b0001;
            w_off = 13'(bus.dn_addr);
        end else if (bus.dn_addr < C_R1_END) begin
            w_sel = 4'b0010;
            w_off = 13'(bus.dn_addr - C_R0_END);
        end else if (bus.dn_addr < C_R2_END) begin
            w_sel = 4'b0100;
            w_off = 13'(bus.dn_addr - C_R1_END);
        end else if (bus.dn_addr < C_R3_END) begin
            w_sel = 4'b1000;
            w_off = 13'(bus.dn_addr - C_R2_END);
        end
    end

    assign w_hit = |w_sel;

    // Count as seen after this cycle's byte, so a byte arriving with the
    // download-end edge still takes part in the length check
    always_comb begin
        w_cnt_next = byte_count;
        if (bus.dn_wr && w_hit && (byte_count != C_CNT_MAX)) begin
            w_cnt_next = byte_count + 17'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_SETTLE;
            settle_cnt   <= C_CNT_RELOAD;
            bus.rom_we   <= 4'b0000;
            bus.rom_addr <= 13'd0;
            bus.rom_data <= 8'd0;
            core_reset_n <= 1'b0;
            dl_busy      <= 1'b0;
            dl_error     <= 1'b0;
            byte_count   <= 17'd0;
        end else begin
            bus.rom_we   <= 4'b0000;
            bus.rom_data <= bus.dn_data;
            case (state)
                ST_SETTLE: begin
                    if (bus.dn_download) begin
                        state      <= ST_LOAD;
                        dl_busy    <= 1'b1;
                        byte_count <= 17'd0;
                        dl_error   <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state        <= ST_RUN;
                        core_reset_n <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                ST_RUN: begin
                    if (bus.dn_download) begin
                        state        <= ST_LOAD;
                        core_reset_n <= 1'b0;
                        dl_busy      <= 1'b1;
                        byte_count   <= 17'd0;
                        dl_error     <= 1'b0;
                    end else if (ext_reset) begin
                        state        <= ST_SETTLE;
                        settle_cnt   <= C_CNT_RELOAD;
                        core_reset_n <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (bus.dn_wr) begin
                        if (w_hit) begin
                            bus.rom_we   <= w_sel;
                            bus.rom_addr <= w_off;
                        end else begin
                            dl_error <= 1'b1;
                        end
                    end
                    byte_count <= w_cnt_next;
                    if (!bus.dn_download) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= C_CNT_RELOAD;
                        dl_busy    <= 1'b0;
                        if (w_cnt_next != C_R3_END) begin
                            dl_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= ST_SETTLE;
                    settle_cnt   <= C_CNT_RELOAD;
                    core_reset_n <= 1'b0;
                    dl_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprint2_rom_loader.sv
// ============================================================================
// Module  : tb_sprint2_rom_loader
// Purpose : Directed self-checking bench for sprint2_rom_loader.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sprint2_rom_loader;

    logic        clk_sys = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ext_reset = 1'b0;
    logic        core_reset_n;
    logic        dl_busy;
    logic        dl_error;
    logic [16:0] byte_count;

    int checks   = 0;
    int failures = 0;

    sprint2_rom_loader_if bus ();

    sprint2_rom_loader dut (
        .clk_sys      (clk_sys),
        .Reset_n      (Reset_n),
        .bus          (bus.slave),
        .ext_reset    (ext_reset),
        .core_reset_n (core_reset_n),
        .dl_busy      (dl_busy),
        .dl_error     (dl_error),
        .byte_count   (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Cycles until core_reset_n rises, bounded so a stuck reset cannot hang
    task automatic settle_len(output int n);
        n = 0;
        while (core_reset_n !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
    endtask

    function automatic int region_bytes(input int total, input int base, input int size);
        int e;
        e = total - base;
        if (e < 0) e = 0;
        if (e > size) e = size;
        return e;
    endfunction

    task automatic download(input int nbytes, input bit merge_exit, input string tag);
        int cnt [4];
        bit multi;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        multi = 1'b0;
        bus.dn_download = 1'b1;
        tick();
        chk({tag, "_busy"},    32'(dl_busy), 32'd1);
        chk({tag, "_err_clr"}, 32'(dl_error), 32'd0);
        chk({tag, "_cnt_clr"}, 32'(byte_count), 32'd0);
        for (int a = 0; a < nbytes; a++) begin
            bus.dn_wr   = 1'b1;
            bus.dn_addr = 17'(a);
            bus.dn_data = 8'(a) ^ 8'hA5;
            if (merge_exit && a == nbytes - 1) bus.dn_download = 1'b0;
            tick();
            for (int i = 0; i < 4; i++) if (bus.rom_we[i]) cnt[i]++;
            if ($countones(bus.rom_we) != 1) multi = 1'b1;
            if (a == 32'h1FFF) begin
                chk({tag, "_we_1fff"},   32'(bus.rom_we), 32'h1);
                chk({tag, "_addr_1fff"}, 32'(bus.rom_addr), 32'h1FFF);
                chk({tag, "_data_1fff"}, 32'(bus.rom_data), 32'h5A);
            end
            if (a == 32'h2000) begin
                chk({tag, "_we_2000"},   32'(bus.rom_we), 32'h2);
                chk({tag, "_addr_2000"}, 32'(bus.rom_addr), 32'h0);
            end
            if (a == 32'h37FF) begin
                chk({tag, "_we_37ff"},   32'(bus.rom_we), 32'h8);
                chk({tag, "_addr_37ff"}, 32'(bus.rom_addr), 32'h7FF);
            end
        end
        bus.dn_wr = 1'b0;
        if (!merge_exit) begin
            bus.dn_download = 1'b0;
            tick();
            chk({tag, "_we_idle"}, 32'(bus.rom_we), 32'd0);
        end
        chk({tag, "_busy_off"}, 32'(dl_busy), 32'd0);
        chk({tag, "_onehot"},   32'(multi), 32'd0);
        chk({tag, "_r0_cnt"}, 32'(cnt[0]), 32'(region_bytes(nbytes, 32'h0000, 32'h2000)));
        chk({tag, "_r1_cnt"}, 32'(cnt[1]), 32'(region_bytes(nbytes, 32'h2000, 32'h0800)));
        chk({tag, "_r2_cnt"}, 32'(cnt[2]), 32'(region_bytes(nbytes, 32'h2800, 32'h0800)));
        chk({tag, "_r3_cnt"}, 32'(cnt[3]), 32'(region_bytes(nbytes, 32'h3000, 32'h0800)));
    endtask

    task automatic wr_byte(input logic [16:0] addr, input logic [7:0] data);
        bus.dn_wr   = 1'b1;
        bus.dn_addr = addr;
        bus.dn_data = data;
        tick();
        bus.dn_wr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.dn_download = 1'b0;
        bus.dn_wr       = 1'b0;
        bus.dn_addr     = 17'd0;
        bus.dn_data     = 8'd0;

        // Reset values
        tick();
        tick();
        chk("rst_we",       32'(bus.rom_we), 32'd0);
        chk("rst_addr",     32'(bus.rom_addr), 32'd0);
        chk("rst_data",     32'(bus.rom_data), 32'd0);
        chk("rst_core",     32'(core_reset_n), 32'd0);
        chk("rst_busy",     32'(dl_busy), 32'd0);
        chk("rst_err",      32'(dl_error), 32'd0);
        chk("rst_cnt",      32'(byte_count), 32'd0);

        // 1: power-on settle
        Reset_n = 1'b1;
        settle_len(n);
        chk("por_settle", 32'(n), 32'd1024);
        chk("por_err",    32'(dl_error), 32'd0);

        // 2: full download
        download(32'h3800, 1'b0, "full");
        chk("full_cnt", 32'(byte_count), 32'h3800);
        chk("full_err", 32'(dl_error), 32'd0);
        chk("full_core_low", 32'(core_reset_n), 32'd0);
        settle_len(n);
        chk("full_settle", 32'(n), 32'd1024);

        // 3: short download, then a full one with the last byte on the exit edge
        download(32'h3000, 1'b0, "short");
        chk("short_cnt", 32'(byte_count), 32'h3000);
        chk("short_err", 32'(dl_error), 32'd1);
        settle_len(n);
        download(32'h3800, 1'b1, "full2");
        chk("full2_cnt", 32'(byte_count), 32'h3800);
        chk("full2_err", 32'(dl_error), 32'd0);
        settle_len(n);
        chk("full2_settle", 32'(n), 32'd1024);

        // 5a: ext_reset while running
        ext_reset = 1'b1;
        tick();
        ext_reset = 1'b0;
        chk("ext_core_low", 32'(core_reset_n), 32'd0);
        settle_len(n);
        chk("ext_settle", 32'(n), 32'd1024);

        // 4: out-of-range bytes
        bus.dn_download = 1'b1;
        tick();
        wr_byte(17'h03800, 8'h11);
        chk("oor_we",  32'(bus.rom_we), 32'd0);
        chk("oor_err", 32'(dl_error), 32'd1);
        chk("oor_cnt", 32'(byte_count), 32'd0);
        wr_byte(17'h1FFFF, 8'h22);
        chk("oor_max_we",  32'(bus.rom_we), 32'd0);
        chk("oor_max_cnt", 32'(byte_count), 32'd0);
        wr_byte(17'h00005, 8'h3C);
        chk("in_we",   32'(bus.rom_we), 32'h1);
        chk("in_addr", 32'(bus.rom_addr), 32'h5);
        chk("in_data", 32'(bus.rom_data), 32'h3C);
        chk("in_cnt",  32'(byte_count), 32'h1);
        chk("in_err_sticky", 32'(dl_error), 32'd1);

        // 5b: ext_reset ignored in LOAD
        ext_reset = 1'b1;
        tick();
        tick();
        tick();
        ext_reset = 1'b0;
        chk("ext_load_busy", 32'(dl_busy), 32'd1);
        chk("ext_load_core", 32'(core_reset_n), 32'd0);
        bus.dn_download = 1'b0;
        tick();
        chk("oor_exit_err", 32'(dl_error), 32'd1);

        // 5c: download request mid-settle
        repeat (100) tick();
        chk("mid_settle_core", 32'(core_reset_n), 32'd0);
        bus.dn_download = 1'b1;
        tick();
        chk("mid_settle_load", 32'(dl_busy), 32'd1);
        chk("mid_settle_errclr", 32'(dl_error), 32'd0);

        // 6: async reset just as a strobe becomes visible
        wr_byte(17'h02801, 8'h77);
        chk("pre_rst_we",   32'(bus.rom_we), 32'h4);
        chk("pre_rst_addr", 32'(bus.rom_addr), 32'h1);
        Reset_n = 1'b0;
        #1;
        chk("arst_we",   32'(bus.rom_we), 32'd0);
        chk("arst_addr", 32'(bus.rom_addr), 32'd0);
        chk("arst_cnt",  32'(byte_count), 32'd0);
        chk("arst_busy", 32'(dl_busy), 32'd0);
        bus.dn_download = 1'b0;
        #1;
        Reset_n = 1'b1;
        settle_len(n);
        chk("arst_settle", 32'(n), 32'd1024);
        chk("arst_err",    32'(dl_error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
